rs_addsub: RTL and testbench
============================

Name: rs_addsub

Overview:
Reservation station that feeds the add/sub functional unit in the Tomasulo datapath. It accepts issued add/sub instructions from the issue stage and holds each one in an entry whose index defines its Label. Entries wait on the common data bus (CDB) for missing operands. Each cycle at most one ready entry is dispatched to the FU as en/Rx/Ry/Op/Label.

Parameters:
DEPTH, 2, number of station entries (1..4).
DATA_W, 12, operand/result width.
LABEL_W, 2, tag width; Label space shared by all stations.
LABEL_BASE, 0, Label of entry 0; entry i owns Label LABEL_BASE+i. Requires LABEL_BASE+DEPTH <= 2**LABEL_W.

Ports:
Clock  in  1  system clock; all state updates on posedge.
Resetn  in  1  synchronous active-low reset.
issue_valid  in  1  issue stage presents an instruction.
issue_op  in  3  3'b000 add, 3'b001 sub.
issue_vj, issue_vk  in  DATA_W  operand values, meaningful when the matching rdy bit is 1.
issue_rj, issue_rk  in  1  1 = operand value present; 0 = waiting on a tag.
issue_qj, issue_qk  in  LABEL_W  producer tag when the matching rdy bit is 0.
issue_ready  out  1  at least one entry free (registered state).
issue_label  out  LABEL_W  Label the next accepted instruction receives (lowest free entry).
cdb_valid  in  1  CDB broadcast valid.
cdb_label  in  LABEL_W  producing tag.
cdb_data  in  DATA_W  broadcast value.
fu_en  out  1  dispatch strobe to FU en.
fu_Rx, fu_Ry  out  DATA_W  operands.
fu_Op  out  3  opcode.
fu_Label  out  LABEL_W  Label of the dispatched entry.
occupancy  out  3  count of busy entries.

Behaviour:
- Reset (Resetn=0 at posedge): all entries not busy, all operand-ready flags 0. fu_en=0, fu_Rx=fu_Ry=0, fu_Op=0, fu_Label=0, occupancy=0. Reset wins over issue, CDB and dispatch in the same cycle. Reset mid-operation discards all entries; a dispatch registered before reset stays visible for that cycle only.
- Entry state: busy, op, vj, vk, rj, rk, qj, qk.
- Issue: accepted when issue_valid and issue_ready. Writes the lowest-index non-busy entry. Issue and dispatch may occur in the same cycle. A slot freed by dispatch becomes allocatable next cycle. issue_valid while not ready is ignored; upstream must hold.
- Issue/CDB collision: if cdb_valid and cdb_label equals the issued qj (with rj=0), the entry captures cdb_data with rj=1. Same rule for k.
- Wakeup: for every busy entry with rX=0 and qX==cdb_label under cdb_valid: vX<=cdb_data, rX<=1.
- Ready: busy && rj && rk in registered state. An operand woken this cycle dispatches no earlier than next cycle; there is no same-cycle CDB-to-FU bypass.
- Dispatch: if any entry is ready, the selected entry drives registered fu_en=1, fu_Rx=vj, fu_Ry=vk, fu_Op=op, fu_Label=LABEL_BASE+index. Its busy clears at the same posedge. Otherwise fu_en=0 and the data outputs hold their previous values. Latency from a fully-ready issue to fu_en is 1 cycle; the FU samples on the following negedge.
- Selection without the optional feature: lowest index wins.
- The FU is treated as single-cycle and always available; one dispatch per cycle maximum.
- occupancy = popcount(busy), registered.
- Full: issue_ready=0 and issue_label holds the last free-search result. Empty: fu_en=0.
- Unknown opcodes are stored and dispatched unchanged; the FU ignores them.

Optional Feature:
RS_AGE_PRIORITY_EN — defined: each entry stores an issue sequence number from a wrapping counter of clog2(DEPTH)+1 bits that increments per accepted issue. Dispatch selects the oldest ready entry, using modulo distance from the counter. Undefined: no sequence storage, lowest-index priority. Both variants give identical results for a single in-flight entry.

Decomposition:
- Package rs_pkg: OP_ADD=3'b000, OP_SUB=3'b001, DATA_W, LABEL_W, packed rs_entry_t {busy, op, vj, vk, rj, rk, qj, qk[, seq]}.
- One sub-module rs_pick: combinational ready-vector -> grant index + valid, with an age compare when RS_AGE_PRIORITY_EN is defined.

Test Plan:
1. Reset then issue add, vj=5, vk=3, rj=rk=1 -> issue_label=0; next cycle fu_en=1, Rx=5, Ry=3, Op=000, Label=0; occupancy back to 0.
2. Issue sub, vj=10 ready, qk=2 not ready -> no dispatch; CDB label=2, data=4 -> next cycle fu_en=1, Rx=10, Ry=4, Op=001.
3. Issue with qj=3 while the CDB broadcasts label 3, data 0xFFF in the same cycle -> captured; dispatched next cycle with Rx=0xFFF.
4. Fill both entries with waiting operands -> issue_ready=0, occupancy=2. A further issue_valid is ignored. Wake both with one CDB -> entry 0 dispatches, then entry 1 the following cycle.
5. Assert Resetn=0 with both entries busy and the CDB active -> all cleared; fu_en=0 after, no stale dispatch.
6. With RS_AGE_PRIORITY_EN: issue A into entry 1, then B into entry 0 (both waiting on tag 2); wake both -> A dispatches first. Without the macro -> B dispatches first.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the add/sub reservation station: opcodes, widths, entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: RS_AGE_PRIORITY_EN adds a per-entry issue sequence field.
package rs_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // Widths live here because the packed entry layout depends on them.
    localparam int DATA_W  = 12;
    localparam int LABEL_W = 2;

    // Sequence field is sized for the largest supported station (4 entries):
    // clog2(4)+1 = 3 bits. Smaller stations wrap the counter at a lower modulus.
    localparam int SEQ_W = 3;

    typedef struct packed {
        logic               busy;
        logic [2:0]         op;
        logic [DATA_W-1:0]  vj;
        logic [DATA_W-1:0]  vk;
        logic               rj;
        logic               rk;
        logic [LABEL_W-1:0] qj;
        logic [LABEL_W-1:0] qk;
`ifdef RS_AGE_PRIORITY_EN
        logic [SEQ_W-1:0]   seq;
`endif
    } rs_entry_t;

endpackage

// File: rtl/rs_pick.sv
// Dispatch arbiter: ready vector in, one grant index plus valid out.
// Latency: purely combinational.
// Backpressure: none; the FU is always available so a grant is always taken.
// Ports: ready[DEPTH] (entry may dispatch), age[DEPTH] (only with
// RS_AGE_PRIORITY_EN: larger means older), grant_vld, grant_idx.
// Without RS_AGE_PRIORITY_EN the lowest ready index wins.
module rs_pick
    import rs_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 1
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_PRIORITY_EN
    input  logic [DEPTH-1:0][SEQ_W-1:0] age,
`endif
    output logic                        grant_vld,
    output logic [IDX_W-1:0]            grant_idx
);

`ifdef RS_AGE_PRIORITY_EN
    logic [SEQ_W-1:0] best_age;

    // Live entries always have distinct ages, so a strict compare is enough.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        best_age  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && (!grant_vld || (age[i] > best_age))) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
                best_age  = age[i];
            end
        end
    end
`else
    // Scan from the top down so the lowest ready index is the last writer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/rs_addsub.sv
// Reservation station for the add/sub FU: holds issued ops, captures CDB operands, dispatches one ready op per cycle.
// Latency: fully-ready issue -> fu_en one cycle later; CDB wakeup -> dispatch no earlier than the following cycle.
// Backpressure: issue_ready low when every entry is busy; issue_valid is ignored then and upstream holds.
// Ports: Clock, Resetn (sync, active low); issue_* (instruction in, issue_ready/issue_label out);
// cdb_* (broadcast in); fu_en/fu_Rx/fu_Ry/fu_Op/fu_Label (registered dispatch out); occupancy.
// Optional feature macro: RS_AGE_PRIORITY_EN selects oldest-ready dispatch instead of lowest index.
module rs_addsub
    import rs_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LABEL_BASE = 0
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               issue_valid,
    input  logic [2:0]         issue_op,
    input  logic [DATA_W-1:0]  issue_vj,
    input  logic [DATA_W-1:0]  issue_vk,
    input  logic               issue_rj,
    input  logic               issue_rk,
    input  logic [LABEL_W-1:0] issue_qj,
    input  logic [LABEL_W-1:0] issue_qk,
    output logic               issue_ready,
    output logic [LABEL_W-1:0] issue_label,
    input  logic               cdb_valid,
    input  logic [LABEL_W-1:0] cdb_label,
    input  logic [DATA_W-1:0]  cdb_data,
    output logic               fu_en,
    output logic [DATA_W-1:0]  fu_Rx,
    output logic [DATA_W-1:0]  fu_Ry,
    output logic [2:0]         fu_Op,
    output logic [LABEL_W-1:0] fu_Label,
    output logic [2:0]         occupancy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t ent_q [DEPTH];
    rs_entry_t ent_d [DEPTH];
    rs_entry_t new_ent;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_fire;
    logic [LABEL_W-1:0] last_label_q;
    logic [DEPTH-1:0]   rdy_vec;
    logic               grant_vld;
    logic [IDX_W-1:0]   grant_idx;
    logic               hit_j;
    logic               hit_k;

`ifdef RS_AGE_PRIORITY_EN
    // Counter wraps at 2**(clog2(DEPTH)+1), at least twice the entry count,
    // so modulo distance from the counter orders all live entries uniquely.
    localparam int               AGE_W    = $clog2(DEPTH) + 1;
    localparam logic [SEQ_W-1:0] SEQ_MASK = SEQ_W'((1 << AGE_W) - 1);

    logic [SEQ_W-1:0]            seq_cnt;
    logic [DEPTH-1:0][SEQ_W-1:0] age_vec;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_vec[i] = (seq_cnt - ent_q[i].seq) & SEQ_MASK;
        end
    end
`endif

    // Lowest-index free entry, from registered busy only: a slot freed by
    // this cycle's dispatch is not allocatable until next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_fire  = issue_valid && free_found;
    assign issue_ready = free_found;
    assign issue_label = free_found ? (LABEL_W'(LABEL_BASE) + LABEL_W'(free_idx)) : last_label_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent_q[i].busy && ent_q[i].rj && ent_q[i].rk;
        end
    end

    rs_pick #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .ready     (rdy_vec),
`ifdef RS_AGE_PRIORITY_EN
        .age       (age_vec),
`endif
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    // An operand being broadcast in the issue cycle is captured directly,
    // otherwise the tag would be missed forever.
    always_comb begin
        hit_j           = cdb_valid && !issue_rj && (issue_qj == cdb_label);
        hit_k           = cdb_valid && !issue_rk && (issue_qk == cdb_label);
        new_ent         = '0;
        new_ent.busy    = 1'b1;
        new_ent.op      = issue_op;
        new_ent.vj      = hit_j ? cdb_data : issue_vj;
        new_ent.vk      = hit_k ? cdb_data : issue_vk;
        new_ent.rj      = issue_rj || hit_j;
        new_ent.rk      = issue_rk || hit_k;
        new_ent.qj      = issue_qj;
        new_ent.qk      = issue_qk;
`ifdef RS_AGE_PRIORITY_EN
        new_ent.seq     = seq_cnt;
`endif
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].busy && cdb_valid) begin
                if (!ent_q[i].rj && (ent_q[i].qj == cdb_label)) begin
                    ent_d[i].vj = cdb_data;
                    ent_d[i].rj = 1'b1;
                end
                if (!ent_q[i].rk && (ent_q[i].qk == cdb_label)) begin
                    ent_d[i].vk = cdb_data;
                    ent_d[i].rk = 1'b1;
                end
            end
            if (grant_vld && (grant_idx == IDX_W'(i))) begin
                ent_d[i].busy = 1'b0;
            end
            // Issue only targets a slot that was free in registered state,
            // so it never collides with the dispatched slot.
            if (issue_fire && (free_idx == IDX_W'(i))) begin
                ent_d[i] = new_ent;
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + 3'(ent_q[i].busy);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            fu_en        <= 1'b0;
            fu_Rx        <= '0;
            fu_Ry        <= '0;
            fu_Op        <= '0;
            fu_Label     <= '0;
            last_label_q <= LABEL_W'(LABEL_BASE);
`ifdef RS_AGE_PRIORITY_EN
            seq_cnt      <= '0;
`endif
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            fu_en <= grant_vld;
            // Data outputs hold their last dispatch when nothing is granted.
            if (grant_vld) begin
                fu_Rx    <= ent_q[grant_idx].vj;
                fu_Ry    <= ent_q[grant_idx].vk;
                fu_Op    <= ent_q[grant_idx].op;
                fu_Label <= LABEL_W'(LABEL_BASE) + LABEL_W'(grant_idx);
            end
            if (free_found) begin
                last_label_q <= LABEL_W'(LABEL_BASE) + LABEL_W'(free_idx);
            end
`ifdef RS_AGE_PRIORITY_EN
            if (issue_fire) begin
                seq_cnt <= (seq_cnt + SEQ_W'(1)) & SEQ_MASK;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rs_addsub.sv
// Self-checking bench for rs_addsub: directed scenarios then randomized traffic against a slot-level model.
// Latency: model advances once per Clock posedge; outputs sampled 1 time unit after the edge.
// Backpressure: model ignores issue while every slot is occupied, like upstream would see.
module tb_rs_addsub;
    import rs_pkg::*;

    localparam int DEPTH      = 2;
    localparam int LABEL_BASE = 0;

    logic               Clock;
    logic               Resetn;
    logic               issue_valid;
    logic [2:0]         issue_op;
    logic [DATA_W-1:0]  issue_vj, issue_vk;
    logic               issue_rj, issue_rk;
    logic [LABEL_W-1:0] issue_qj, issue_qk;
    logic               issue_ready;
    logic [LABEL_W-1:0] issue_label;
    logic               cdb_valid;
    logic [LABEL_W-1:0] cdb_label;
    logic [DATA_W-1:0]  cdb_data;
    logic               fu_en;
    logic [DATA_W-1:0]  fu_Rx, fu_Ry;
    logic [2:0]         fu_Op;
    logic [LABEL_W-1:0] fu_Label;
    logic [2:0]         occupancy;

    rs_addsub #(.DEPTH(DEPTH), .LABEL_BASE(LABEL_BASE)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_vj    (issue_vj),
        .issue_vk    (issue_vk),
        .issue_rj    (issue_rj),
        .issue_rk    (issue_rk),
        .issue_qj    (issue_qj),
        .issue_qk    (issue_qk),
        .issue_ready (issue_ready),
        .issue_label (issue_label),
        .cdb_valid   (cdb_valid),
        .cdb_label   (cdb_label),
        .cdb_data    (cdb_data),
        .fu_en       (fu_en),
        .fu_Rx       (fu_Rx),
        .fu_Ry       (fu_Ry),
        .fu_Op       (fu_Op),
        .fu_Label    (fu_Label),
        .occupancy   (occupancy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one record per slot, age kept as an unbounded issue number.
    bit  m_busy [DEPTH];
    bit  m_rj [DEPTH], m_rk [DEPTH];
    int  m_vj [DEPTH], m_vk [DEPTH], m_qj [DEPTH], m_qk [DEPTH], m_op [DEPTH];
    int  m_order [DEPTH];
    int  m_issue_no;
    bit  m_fu_en;
    int  m_rx, m_ry, m_fop, m_lab, m_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_busy[i] = 0; m_rj[i] = 0; m_rk[i] = 0;
            m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0; m_op[i] = 0; m_order[i] = 0;
        end
        m_issue_no = 0;
        m_fu_en = 0; m_rx = 0; m_ry = 0; m_fop = 0; m_lab = 0;
        m_last = LABEL_BASE;
    endtask

    task automatic model_step();
        int sel;
        int fr;
        if (!Resetn) begin
            model_clear();
            return;
        end
        sel = -1;
        fr  = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_rj[i] && m_rk[i]) begin
`ifdef RS_AGE_PRIORITY_EN
                if (sel < 0 || m_order[i] < m_order[sel]) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
            if (!m_busy[i] && fr < 0) fr = i;
        end
        if (sel >= 0) begin
            m_fu_en = 1;
            m_rx = m_vj[sel]; m_ry = m_vk[sel]; m_fop = m_op[sel]; m_lab = LABEL_BASE + sel;
            m_busy[sel] = 0;
        end else begin
            m_fu_en = 0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_busy[i] && !m_rj[i] && m_qj[i] == int'(cdb_label)) begin m_vj[i] = cdb_data; m_rj[i] = 1; end
                if (m_busy[i] && !m_rk[i] && m_qk[i] == int'(cdb_label)) begin m_vk[i] = cdb_data; m_rk[i] = 1; end
            end
        end
        if (issue_valid && fr >= 0) begin
            m_busy[fr] = 1;
            m_op[fr] = issue_op;
            m_qj[fr] = issue_qj; m_qk[fr] = issue_qk;
            m_rj[fr] = issue_rj; m_rk[fr] = issue_rk;
            m_vj[fr] = issue_vj; m_vk[fr] = issue_vk;
            if (!issue_rj && cdb_valid && issue_qj == cdb_label) begin m_rj[fr] = 1; m_vj[fr] = cdb_data; end
            if (!issue_rk && cdb_valid && issue_qk == cdb_label) begin m_rk[fr] = 1; m_vk[fr] = cdb_data; end
            m_order[fr] = m_issue_no;
            m_issue_no++;
        end
        if (fr >= 0) m_last = LABEL_BASE + fr;
    endtask

    task automatic check_outputs();
        int fr;
        int cnt;
        fr = -1;
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_busy[i] && fr < 0) fr = i;
            if (m_busy[i]) cnt++;
        end
        check("fu_en",       32'(fu_en),       32'(m_fu_en));
        check("fu_Rx",       32'(fu_Rx),       32'(m_rx));
        check("fu_Ry",       32'(fu_Ry),       32'(m_ry));
        check("fu_Op",       32'(fu_Op),       32'(m_fop));
        check("fu_Label",    32'(fu_Label),    32'(m_lab));
        check("occupancy",   32'(occupancy),   32'(cnt));
        check("issue_ready", 32'(issue_ready), 32'(fr >= 0));
        check("issue_label", 32'(issue_label), 32'((fr >= 0) ? (LABEL_BASE + fr) : m_last));
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
        issue_rj = 0; issue_rk = 0; issue_qj = 0; issue_qk = 0;
        cdb_valid = 0; cdb_label = 0; cdb_data = 0;
    endtask

    task automatic put_issue(input logic [2:0] op, input int vj, input int vk,
                             input bit rj, input bit rk, input int qj, input int qk);
        issue_valid = 1; issue_op = op;
        issue_vj = DATA_W'(vj); issue_vk = DATA_W'(vk);
        issue_rj = rj; issue_rk = rk;
        issue_qj = LABEL_W'(qj); issue_qk = LABEL_W'(qk);
    endtask

    task automatic put_cdb(input int lab, input int data);
        cdb_valid = 1; cdb_label = LABEL_W'(lab); cdb_data = DATA_W'(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        Resetn = 0;
        model_clear();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1;

        // 1: fully ready add dispatches one cycle after issue
        check("t1_issue_label", 32'(issue_label), 32'(0));
        check("t1_occ_reset",   32'(occupancy),   32'(0));
        put_issue(OP_ADD, 5, 3, 1, 1, 0, 0);
        cycle();
        idle();
        cycle();
        check("t1_fu_en", 32'(fu_en),    32'(1));
        check("t1_rx",    32'(fu_Rx),    32'(5));
        check("t1_ry",    32'(fu_Ry),    32'(3));
        check("t1_op",    32'(fu_Op),    32'(0));
        check("t1_label", 32'(fu_Label), 32'(0));
        check("t1_occ",   32'(occupancy), 32'(0));
        cycle();

        // 2: sub waits on tag 2, woken by CDB
        put_issue(OP_SUB, 10, 0, 1, 0, 0, 2);
        cycle();
        idle();
        cycle();
        put_cdb(2, 4);
        cycle();
        idle();
        cycle();
        check("t2_fu_en", 32'(fu_en), 32'(1));
        check("t2_rx",    32'(fu_Rx), 32'(10));
        check("t2_ry",    32'(fu_Ry), 32'(4));
        check("t2_op",    32'(fu_Op), 32'(1));

        // 3: issue/CDB collision on j
        put_issue(OP_ADD, 0, 1, 0, 1, 3, 0);
        put_cdb(3, 12'hFFF);
        cycle();
        idle();
        cycle();
        check("t3_fu_en", 32'(fu_en), 32'(1));
        check("t3_rx",    32'(fu_Rx), 32'(12'hFFF));

        // 4: fill, ignored issue while full, single wake of both
        put_issue(OP_ADD, 0, 7, 0, 1, 2, 0);
        cycle();
        put_issue(OP_SUB, 0, 8, 0, 1, 2, 0);
        cycle();
        check("t4_ready_full", 32'(issue_ready), 32'(0));
        check("t4_occ_full",   32'(occupancy),   32'(2));
        put_issue(OP_ADD, 9, 9, 1, 1, 0, 0);
        cycle();
        idle();
        put_cdb(2, 12'h055);
        cycle();
        idle();
        cycle();
        check("t4_first_label",  32'(fu_Label), 32'(0));
        cycle();
        check("t4_second_en",    32'(fu_en),    32'(1));
        check("t4_second_label", 32'(fu_Label), 32'(1));
        cycle();

        // 5: reset while full with CDB active
        put_issue(OP_ADD, 1, 0, 1, 0, 0, 3);
        cycle();
        put_issue(OP_SUB, 0, 2, 0, 1, 3, 0);
        cycle();
        put_issue(OP_ADD, 4, 4, 1, 1, 0, 0);
        put_cdb(3, 12'h123);
        Resetn = 0;
        cycle();
        Resetn = 1;
        idle();
        check("t5_occ",  32'(occupancy), 32'(0));
        check("t5_en",   32'(fu_en),     32'(0));
        check("t5_rx",   32'(fu_Rx),     32'(0));
        cycle();
        check("t5_no_stale", 32'(fu_en), 32'(0));
        cycle();

        // 6: A lands in entry 1, later B in entry 0; priority decides the order
        put_issue(OP_ADD, 1, 1, 1, 1, 0, 0);
        cycle();
        put_issue(OP_ADD, 12'h0A, 0, 1, 0, 0, 2);
        cycle();
        put_issue(OP_SUB, 12'h0B, 0, 1, 0, 0, 2);
        cycle();
        idle();
        put_cdb(2, 6);
        cycle();
        idle();
        cycle();
`ifdef RS_AGE_PRIORITY_EN
        check("t6_first", 32'(fu_Rx), 32'(12'h0A));
`else
        check("t6_first", 32'(fu_Rx), 32'(12'h0B));
`endif
        cycle();
        cycle();

        // Randomized traffic, including unknown opcodes and occasional reset
        for (int n = 0; n < 400; n++) begin
            Resetn      = ($urandom_range(0, 49) != 0);
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_op    = 3'($urandom_range(0, 7));
            issue_vj    = DATA_W'($urandom);
            issue_vk    = DATA_W'($urandom);
            issue_rj    = $urandom_range(0, 1) == 1;
            issue_rk    = $urandom_range(0, 1) == 1;
            issue_qj    = LABEL_W'($urandom_range(0, 3));
            issue_qk    = LABEL_W'($urandom_range(0, 3));
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_label   = LABEL_W'($urandom_range(0, 3));
            cdb_data    = DATA_W'($urandom);
            cycle();
        end
        Resetn = 1;
        idle();
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
